// File: rtl/xbar_nxn_rr_if.sv
// xbar_nxn_rr_if: port bundle for the NxN crossbar; out_count exists only with XBAR_COUNT_EN
interface xbar_nxn_rr_if #(parameter int N = 4, parameter int W = 8);
  localparam int DW = $clog2(N);
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [N*W-1:0] in_data;
  logic [N*DW-1:0] in_dest;
  logic [N-1:0] out_valid;
  logic [N-1:0] out_ready;
  logic [N*W-1:0] out_data;
  logic [N*DW-1:0] out_src;
`ifdef XBAR_COUNT_EN
  logic [N*16-1:0] out_count;
`endif
  modport master (
    output in_valid, in_data, in_dest, out_ready,
    input in_ready, out_valid, out_data, out_src
`ifdef XBAR_COUNT_EN
    , input out_count
`endif
  );
  modport slave (
    input in_valid, in_data, in_dest, out_ready,
    output in_ready, out_valid, out_data, out_src
`ifdef XBAR_COUNT_EN
    , output out_count
`endif
  );
endinterface

// File: rtl/xbar_nxn_rr.sv
// xbar_nxn_rr: NxN crossbar, registered outputs, per-output round-robin arbiters; XBAR_COUNT_EN adds per-output transfer counters
module xbar_nxn_rr #(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic clk,
  input logic rst,
  xbar_nxn_rr_if.slave bus
);
  localparam int DW = $clog2(N);
  localparam logic [DW:0] NL = (DW+1)'(N);
  logic [DW-1:0] dst [N];
  logic [DW-1:0] ptr [N];
  logic [DW-1:0] gi [N];
  logic [N-1:0] gv;
  logic [N-1:0] oor;
  logic [N-1:0] xfer;
  logic [N-1:0] rdy;
  logic [N-1:0] ov;
  logic [N*W-1:0] od;
  logic [N*DW-1:0] os;
  // decode destinations, scan requesters from each output's pointer, and form accepts
  always_comb begin
    gv = '0;
    oor = '0;
    rdy = '0;
    xfer = '0;
    for (int i = 0; i < N; i++) begin
      dst[i] = bus.in_dest[i*DW +: DW];
      oor[i] = bus.in_valid[i] && ({1'b0, dst[i]} >= NL);
    end
    for (int j = 0; j < N; j++) begin
      gi[j] = '0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (int'(ptr[j]) + k) % N;
        if (!gv[j] && bus.in_valid[idx] && dst[idx] == DW'(j)) begin
          gv[j] = 1'b1;
          gi[j] = DW'(idx);
        end
      end
      xfer[j] = gv[j] && (!ov[j] || bus.out_ready[j]);
      if (xfer[j]) rdy[gi[j]] = 1'b1;
    end
    rdy = rdy | oor;
  end
  assign bus.in_ready = rst ? '0 : rdy;
  assign bus.out_valid = ov;
  assign bus.out_data = od;
  assign bus.out_src = os;
  // load granted words, drain accepted ones, advance pointers past the winner
  always_ff @(posedge clk) begin
    if (rst) begin
      ov <= '0;
      od <= '0;
      os <= '0;
      for (int j = 0; j < N; j++) ptr[j] <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (xfer[j]) begin
          od[j*W +: W] <= bus.in_data[int'(gi[j])*W +: W];
          os[j*DW +: DW] <= gi[j];
          ov[j] <= 1'b1;
          ptr[j] <= (gi[j] == DW'(N-1)) ? '0 : gi[j] + 1'b1;
        end else if (bus.out_ready[j]) begin
          ov[j] <= 1'b0;
        end
      end
    end
  end
`ifdef XBAR_COUNT_EN
  logic [N*16-1:0] cnt;
  // saturating count of completed output handshakes
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else
      for (int j = 0; j < N; j++)
        if (ov[j] && bus.out_ready[j] && cnt[j*16 +: 16] != 16'hFFFF)
          cnt[j*16 +: 16] <= cnt[j*16 +: 16] + 16'd1;
  end
  assign bus.out_count = cnt;
`endif
endmodule

// File: tb/tb_xbar_nxn_rr.sv
// tb_xbar_nxn_rr: vector table, directed corner cases and a randomized reference-model run for xbar_nxn_rr
module tb_xbar_nxn_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst3 = 1'b1;
  always #5 clk = ~clk;
  xbar_nxn_rr_if #(.N(4), .W(8)) b4();
  xbar_nxn_rr_if #(.N(3), .W(8)) b3();
  xbar_nxn_rr #(.N(4), .W(8)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  xbar_nxn_rr #(.N(3), .W(8)) u3 (.clk(clk), .rst(rst3), .bus(b3.slave));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0] v;
    logic [7:0] dest;
    logic [31:0] data;
    logic [3:0] ordy;
    logic [3:0] rdy;
    logic [3:0] ov;
    logic [31:0] od;
    logic [7:0] os;
  } vec_t;
  vec_t tbl [7];
  int m_v [4];
  int m_d [4];
  int m_s [4];
  int m_last [4];
  logic [3:0] rv;
  int rd [4];
  logic [7:0] rdat [4];
  logic [3:0] rordy;
  logic [3:0] hold;
  logic [3:0] acc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive4(input logic [3:0] v, input logic [7:0] dest, input logic [31:0] data, input logic [3:0] ordy);
    b4.in_valid = v;
    b4.in_dest = dest;
    b4.in_data = data;
    b4.out_ready = ordy;
  endtask

  task automatic model_reset();
    for (int j = 0; j < 4; j++) begin
      m_v[j] = 0;
      m_d[j] = 0;
      m_s[j] = 0;
      m_last[j] = 3;
    end
  endtask

  // winner is the requester nearest after the last one served on that output
  task automatic model_step(output logic [3:0] a);
    a = '0;
    for (int j = 0; j < 4; j++) begin
      int best;
      int bd;
      best = -1;
      bd = 4;
      for (int i = 0; i < 4; i++)
        if (rv[i] && rd[i] == j && ((i - m_last[j] + 3) % 4) < bd) begin
          bd = (i - m_last[j] + 3) % 4;
          best = i;
        end
      if (best >= 0 && (m_v[j] == 0 || rordy[j])) begin
        a[best] = 1'b1;
        m_v[j] = 1;
        m_d[j] = int'(rdat[best]);
        m_s[j] = best;
        m_last[j] = best;
      end else if (rordy[j]) begin
        m_v[j] = 0;
      end
    end
  endtask

  initial begin
    tbl[0] = '{4'hF, 8'h1B, 32'hA3A2A1A0, 4'hF, 4'hF, 4'hF, 32'hA0A1A2A3, 8'h1B};
    tbl[1] = '{4'hF, 8'hE4, 32'hB3B2B1B0, 4'hF, 4'hF, 4'hF, 32'hB3B2B1B0, 8'hE4};
    tbl[2] = '{4'h0, 8'h00, 32'h0, 4'b0101, 4'h0, 4'b1010, 32'hB3B2B1B0, 8'hE4};
    tbl[3] = '{4'h0, 8'h00, 32'h0, 4'b0000, 4'h0, 4'b1010, 32'hB3B2B1B0, 8'hE4};
    tbl[4] = '{4'b0010, 8'h0C, 32'h0000C100, 4'b0000, 4'h0, 4'b1010, 32'hB3B2B1B0, 8'hE4};
    tbl[5] = '{4'b0010, 8'h0C, 32'h0000C100, 4'b1000, 4'b0010, 4'b1010, 32'hC1B2B1B0, 8'h64};
    tbl[6] = '{4'b0101, 8'h00, 32'h00D200D0, 4'hF, 4'b0100, 4'b0001, 32'hC1B2B1D2, 8'h66};
    b3.in_valid = '0;
    b3.in_dest = '0;
    b3.in_data = '0;
    b3.out_ready = '0;
    drive4(4'hF, 8'hAA, 32'h13121110, 4'hF);
    // reset with every input requesting
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_in_ready", 32'(b4.in_ready), 0);
      @(posedge clk); #1;
      chk("rst_out_valid", 32'(b4.out_valid), 0);
      chk("rst_out_data", b4.out_data, 0);
    end
    // contention on output 2: grants rotate 0,1,2,3,0
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_in_ready", 32'(b4.in_ready), 32'(4'b1 << (k % 4)));
      @(posedge clk); #1;
      chk("rr_out_src2", 32'(b4.out_src[5:4]), k % 4);
      chk("rr_out_data2", 32'(b4.out_data[23:16]), 32'h10 + k % 4);
      @(negedge clk);
    end
    // backpressure on output 1
    drive4(4'b0001, 8'h01, 32'h55, 4'h0);
    #1;
    chk("bp_load_ready", 32'(b4.in_ready), 32'h1);
    @(posedge clk); #1;
    chk("bp_load_data", 32'(b4.out_data[15:8]), 32'h55);
    @(negedge clk);
    drive4(4'b0001, 8'h01, 32'h66, 4'h0);
    repeat (5) begin
      #1;
      chk("bp_stall_ready", 32'(b4.in_ready[0]), 0);
      @(posedge clk); #1;
      chk("bp_hold_data", 32'(b4.out_data[15:8]), 32'h55);
      chk("bp_hold_valid", 32'(b4.out_valid[1]), 1);
      @(negedge clk);
    end
    b4.out_ready = 4'b0010;
    #1;
    chk("bp_release_ready", 32'(b4.in_ready), 32'h1);
    @(posedge clk); #1;
    chk("bp_new_data", 32'(b4.out_data[15:8]), 32'h66);
    // vector table from a fresh reset
    @(negedge clk);
    drive4(4'h0, 8'h0, 32'h0, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 7; r++) begin
      drive4(tbl[r].v, tbl[r].dest, tbl[r].data, tbl[r].ordy);
      #1;
      chk($sformatf("tbl%0d_in_ready", r), 32'(b4.in_ready), 32'(tbl[r].rdy));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_out_valid", r), 32'(b4.out_valid), 32'(tbl[r].ov));
      chk($sformatf("tbl%0d_out_data", r), b4.out_data, tbl[r].od);
      chk($sformatf("tbl%0d_out_src", r), 32'(b4.out_src), 32'(tbl[r].os));
      @(negedge clk);
    end
    // reset while an output holds data
    drive4(4'h0, 8'h0, 32'h0, 4'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(b4.out_valid), 0);
    chk("midrst_out_data", b4.out_data, 0);
    // N=3: out-of-range destination is dropped
    @(negedge clk);
    rst3 = 1'b0;
    b3.in_valid = 3'b001;
    b3.in_dest = 6'b00_00_00;
    b3.in_data = 24'h000077;
    #1;
    chk("n3_load_ready", 32'(b3.in_ready), 32'b001);
    @(posedge clk); #1;
    chk("n3_load_valid", 32'(b3.out_valid), 32'b001);
    @(negedge clk);
    b3.in_valid = 3'b010;
    b3.in_dest = 6'b00_11_00;
    b3.in_data = 24'h008800;
    #1;
    chk("n3_oor_ready", 32'(b3.in_ready), 32'b010);
    @(posedge clk); #1;
    chk("n3_oor_valid", 32'(b3.out_valid), 32'b001);
    chk("n3_oor_data", 32'(b3.out_data), 32'h000077);
    // randomized traffic against the reference model
    @(negedge clk);
    b3.in_valid = '0;
    rst = 1'b0;
    model_reset();
    hold = '0;
    rv = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        if (!hold[i]) begin
          rv[i] = ($urandom_range(3) != 0);
          rd[i] = $urandom_range(3);
          rdat[i] = 8'($urandom);
        end
      rordy = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        b4.in_dest[i*2 +: 2] = 2'(rd[i]);
        b4.in_data[i*8 +: 8] = rdat[i];
      end
      b4.in_valid = rv;
      b4.out_ready = rordy;
      #1;
      for (int j = 0; j < 4; j++) begin
        chk("rand_out_valid", 32'(b4.out_valid[j]), m_v[j]);
        if (m_v[j] != 0) begin
          chk("rand_out_data", 32'(b4.out_data[j*8 +: 8]), m_d[j]);
          chk("rand_out_src", 32'(b4.out_src[j*2 +: 2]), m_s[j]);
        end
      end
      model_step(acc);
      chk("rand_in_ready", 32'(b4.in_ready), 32'(acc));
      hold = rv & ~acc;
      @(negedge clk);
    end
`ifdef XBAR_COUNT_EN
    // transfer counter: exact count, saturation, clear
    drive4(4'h0, 8'h0, 32'h0, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive4(4'b0001, 8'h00, 32'h5A, 4'b0001);
    repeat (10) @(posedge clk);
    #1;
    chk("cnt_exact", 32'(b4.out_count[15:0]), 9);
    repeat (70000) @(posedge clk);
    #1;
    chk("cnt_saturate", 32'(b4.out_count[15:0]), 32'hFFFF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("cnt_reset", 32'(b4.out_count), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
